shift_req_ctrl: RTL and testbench
=================================

Name: shift_req_ctrl

Overview:
Command-queue and result-register stage wrapped around the team's combinational 4-bit shifter. It accepts shift requests (operand, signed count, op type) over a valid/ready handshake and buffers them in a small FIFO. It presents the head request to the shifter and registers the shifter's result onto a valid/ready output. It pairs with the shifter so the combinational path sits between two registers and upstream/downstream can stall independently.

Parameters:
WIDTH, 4, operand/result width; must equal shifter width
DEPTH, 2, command FIFO entries; power of 2, >= 2
CNT_W, 4, count field width; two's complement, MSB=1 means right shift by magnitude

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of FIFO and output register
in_valid  input  1  request present
in_ready  output  1  FIFO can accept
in_num  input  WIDTH  operand
in_count  input  CNT_W  signed shift count (neg = right)
in_op  input  1  1 = logical, 0 = arithmetic
sh_num  output  WIDTH  to shifter num
sh_count  output  CNT_W  to shifter count
sh_op  output  1  to shifter op_type
sh_o  input  WIDTH  from shifter o
out_valid  output  1  result present
out_ready  input  1  downstream accepts
out_data  output  WIDTH  registered shift result
out_ovf  output  1  |count| >= WIDTH (all source bits shifted out)

Behaviour:
- Reset (async, rst=1): FIFO empty, rd/wr pointers 0, out_valid=0, out_data=0, out_ovf=0, in_ready=1.
- Push: in_valid & in_ready at an edge writes {in_num,in_count,in_op} at the write pointer; pointer wraps modulo DEPTH.
- in_ready = (occupancy != DEPTH). It depends only on occupancy, not on same-cycle pop. A full FIFO never accepts, even when popping.
- sh_num/sh_count/sh_op = FIFO head fields, straight from storage (no logic). When empty they hold the last head value. Defined value after reset: 0.
- Output FSM, two states:
  - OUT_EMPTY: if FIFO non-empty, at the edge capture sh_o into out_data, compute out_ovf, pop head, go to OUT_FULL.
  - OUT_FULL: hold out_data/out_ovf stable while out_ready=0.
    - If out_ready=1 and FIFO non-empty: capture next result and pop in the same edge; stay OUT_FULL (back-to-back, 1 result/cycle).
    - If out_ready=1 and FIFO empty: go to OUT_EMPTY, out_valid=0.
- out_valid = (state == OUT_FULL).
- Latency: request accepted at edge k into an empty FIFO with OUT_EMPTY gives out_valid=1 after edge k+1.
- Same-edge push and pop: occupancy unchanged; both pointers advance.
- out_ovf: magnitude = count when MSB=0, else two's-complement negation. count=1000 gives magnitude 8, computed at CNT_W+1 bits so it does not wrap. out_ovf=1 when magnitude >= WIDTH.
- flush=1: at the edge, empty the FIFO, reset pointers, go to OUT_EMPTY. A push in the same cycle is discarded. Flush has priority over push and pop.
- Reset mid-operation: all queued and registered results are lost. No output pulses during or after reset until a new request arrives.
- Pointer arithmetic uses log2(DEPTH)+1 bits to distinguish full from empty.

Optional Feature:
Macro SHIFT_REQ_STATS_EN.
- Defined: adds output done_cnt [7:0]. It increments on each out_valid & out_ready handshake and saturates at 255. Cleared by rst and by flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then single request num=1011, count=1111, op=0, out_ready=1 -> out_valid one cycle after accept, out_data=1101, out_ovf=0.
- Same with op=1 -> out_data=0101; num=0011, count=0010, op=1 -> out_data=1100.
- num=1000, count=1000, op=0 -> out_data=1111, out_ovf=1; num=0110, count=0100, op=1 -> out_data=0000, out_ovf=1.
- out_ready=0, push 3 requests (DEPTH=2) -> first registered; FIFO then holds 2 and in_ready=0. Raise out_ready -> results drain in order, one per cycle, no drops or duplicates.
- Continuous in_valid=1 and out_ready=1 for 8 requests -> 8 results on consecutive cycles after 1-cycle latency; in_ready stays 1.
- Flush asserted with FIFO full and out_valid=1 -> next cycle out_valid=0, in_ready=1; request pushed during flush cycle never appears. With SHIFT_REQ_STATS_EN, done_cnt=0 after flush.

Source files
------------

// File: rtl/shift_req_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_req_if                                                 |
// | Description : Request (valid/ready) and result (valid/ready) channels of    |
// |               the shift request controller.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface shift_req_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [CNT_W-1:0] in_count;
    logic             in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_num, in_count, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_num, in_count, in_op, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

`default_nettype wire

// File: rtl/shift_req_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_req_ctrl                                               |
// | Description : Command FIFO and result register around the combinational    |
// |               shifter. Optional macro SHIFT_REQ_STATS_EN adds done_cnt.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_req_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    shift_req_if.slave            bus,
    output logic      [WIDTH-1:0] sh_num,
    output logic      [CNT_W-1:0] sh_count,
    output logic                  sh_op,
    input  wire logic [WIDTH-1:0] sh_o
`ifdef SHIFT_REQ_STATS_EN
    ,
    output logic      [7:0]       done_cnt
`endif
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_num_mem   [DEPTH];
    logic [CNT_W-1:0]   r_count_mem [DEPTH];
    logic               r_op_mem    [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] w_occ;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    logic [CNT_W:0]     w_cnt_ext;
    logic [CNT_W:0]     w_mag;
    logic               w_ovf;

    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_ovf;

    assign w_occ    = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_occ == c_PTR_W'(DEPTH));
    assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];

    // A full FIFO refuses pushes even when a pop happens on the same edge.
    assign bus.in_ready = !w_full;
    assign w_push       = bus.in_valid && !w_full && !flush;

    assign sh_num   = r_num_mem[w_rd_idx];
    assign sh_count = r_count_mem[w_rd_idx];
    assign sh_op    = r_op_mem[w_rd_idx];

    // Magnitude is one bit wider so the most negative count does not wrap.
    assign w_cnt_ext = {sh_count[CNT_W-1], sh_count};
    assign w_mag     = sh_count[CNT_W-1] ? (~w_cnt_ext + (CNT_W+1)'(1)) : w_cnt_ext;
    assign w_ovf     = (w_mag >= (CNT_W+1)'(WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_num_mem[i]   <= '0;
                r_count_mem[i] <= '0;
                r_op_mem[i]    <= 1'b0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_num_mem[w_wr_idx]   <= bus.in_num;
                r_count_mem[w_wr_idx] <= bus.in_count;
                r_op_mem[w_wr_idx]    <= bus.in_op;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            OUT_EMPTY: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (bus.out_ready) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = OUT_EMPTY;
                    end
                end
            end
            default: w_state_nxt = OUT_EMPTY;
        endcase
        if (flush) begin
            w_pop       = 1'b0;
            w_state_nxt = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (flush) begin
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_pop) begin
            r_out_data <= sh_o;
            r_out_ovf  <= w_ovf;
        end
    end

    assign bus.out_valid = (r_state == OUT_FULL);
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;

`ifdef SHIFT_REQ_STATS_EN
    logic [7:0] r_done_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_cnt <= '0;
        end else if (flush) begin
            r_done_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && (r_done_cnt != 8'hFF)) begin
            r_done_cnt <= r_done_cnt + 8'd1;
        end
    end

    assign done_cnt = r_done_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_req_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_req_ctrl                                            |
// | Description : Directed scoreboard bench for shift_req_ctrl with a shifter   |
// |               model closing the sh_* loop.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_req_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] sh_num;
    logic [3:0] sh_count;
    logic       sh_op;
    logic [3:0] sh_o;
`ifdef SHIFT_REQ_STATS_EN
    logic [7:0] done_cnt;
`endif

    shift_req_if #(.WIDTH(4), .CNT_W(4)) bus ();

    shift_req_ctrl #(.WIDTH(4), .DEPTH(2), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .sh_num   (sh_num),
        .sh_count (sh_count),
        .sh_op    (sh_op),
        .sh_o     (sh_o)
`ifdef SHIFT_REQ_STATS_EN
        ,
        .done_cnt (done_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] data;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hs_count = 0;
    int   hs_model = 0;

    // Reference shifter: negative count shifts right by magnitude.
    function automatic logic [3:0] shift_model(input logic [3:0] n, input logic [3:0] c, input logic op);
        int                 sc;
        int                 m;
        logic signed [3:0]  sn;
        sc = $signed(c);
        sn = $signed(n);
        if (sc >= 0) begin
            return (sc >= 4) ? 4'b0000 : (n << sc);
        end
        m = -sc;
        if (op) return (m >= 4) ? 4'b0000 : (n >> m);
        return (m >= 4) ? {4{n[3]}} : 4'(sn >>> m);
    endfunction

    function automatic exp_t expect_of(input logic [3:0] n, input logic [3:0] c, input logic op);
        int   sc;
        exp_t e;
        sc     = $signed(c);
        e.data = shift_model(n, c, op);
        e.ovf  = (sc >= 4) || (sc <= -4);
        return e;
    endfunction

    always_comb sh_o = shift_model(sh_num, sh_count, sh_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes before the edge, then advance past it.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (flush) begin
            q.delete();
            hs_model = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                hs_count++;
                if (hs_model < 255) hs_model++;
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", 32'(bus.out_data), 32'(e.data));
                    chk("sb_ovf", 32'(bus.out_ovf), 32'(e.ovf));
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(expect_of(bus.in_num, bus.in_count, bus.in_op));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] n, input logic [3:0] c, input logic op);
        bus.in_valid = v;
        bus.in_num   = n;
        bus.in_count = c;
        bus.in_op    = op;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic single(input logic [3:0] n, input logic [3:0] c, input logic op,
                          input logic [3:0] d_exp, input logic ovf_exp);
        bus.out_ready = 1'b1;
        drive(1'b1, n, c, op);
        step();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
        step();
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("direct_data", 32'(bus.out_data), 32'(d_exp));
        chk("direct_ovf", 32'(bus.out_ovf), 32'(ovf_exp));
        drain();
        step();
        chk("idle_after", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int hs_start;
        rst   = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_sh_fields", 32'({sh_num, sh_count, sh_op}), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_idle", 32'(bus.out_valid), 32'd0);

        single(4'b1011, 4'b1111, 1'b0, 4'b1101, 1'b0);
        single(4'b1011, 4'b1111, 1'b1, 4'b0101, 1'b0);
        single(4'b0011, 4'b0010, 1'b1, 4'b1100, 1'b0);
        single(4'b1000, 4'b1000, 1'b0, 4'b1111, 1'b1);
        single(4'b0110, 4'b0100, 1'b1, 4'b0000, 1'b1);

        // Backpressure: three requests with out_ready low.
        bus.out_ready = 1'b0;
        drive(1'b1, 4'b0101, 4'b0001, 1'b0); step();
        drive(1'b1, 4'b1001, 4'b1110, 1'b0); step();
        drive(1'b1, 4'b1110, 4'b1101, 1'b1); step();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_first_data", 32'(bus.out_data), 32'(4'b1010));
        step();
        chk("bp_hold_data", 32'(bus.out_data), 32'(4'b1010));
        bus.out_ready = 1'b1;
        hs_start = hs_count;
        for (int i = 0; i < 3; i++) begin
            chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
            step();
        end
        chk("bp_drain_count", 32'(hs_count - hs_start), 32'd3);
        chk("bp_drained_idle", 32'(bus.out_valid), 32'd0);
        chk("bp_q_empty", 32'(q.size()), 32'd0);

        // Streaming: eight back-to-back requests.
        hs_start = hs_count;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            step();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        step();
        step();
        chk("stream_count", 32'(hs_count - hs_start), 32'd8);
        chk("stream_idle", 32'(bus.out_valid), 32'd0);

`ifdef SHIFT_REQ_STATS_EN
        chk("done_cnt_tally", 32'(done_cnt), 32'(hs_model));
`endif

        // Flush with FIFO full and result pending; concurrent push discarded.
        bus.out_ready = 1'b0;
        drive(1'b1, 4'b0001, 4'b0001, 1'b0); step();
        drive(1'b1, 4'b0010, 4'b0001, 1'b0); step();
        drive(1'b1, 4'b0011, 4'b0001, 1'b0); step();
        chk("fl_pre_full", 32'(bus.in_ready), 32'd0);
        chk("fl_pre_valid", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        drive(1'b1, 4'b0111, 4'b0000, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef SHIFT_REQ_STATS_EN
        chk("fl_done_cnt", 32'(done_cnt), 32'd0);
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_no_ghost", 32'(bus.out_valid), 32'd0);
        end

        // Reset mid-operation drops everything.
        drive(1'b1, 4'b1111, 4'b0001, 1'b0); step();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        q.delete();
        hs_model = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_quiet", 32'(bus.out_valid), 32'd0);
        end
        single(4'b0011, 4'b0010, 1'b1, 4'b1100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
